// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
// Holds funct3 access-width codes, trap cause codes and the FSM state type.
// Imported by lsu_if, lsu_align and lsu_ctrl.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_ILL = 4'd2;
  localparam logic [3:0] LD_MISAL  = 4'd4;
  localparam logic [3:0] LD_FAULT  = 4'd5;
  localparam logic [3:0] ST_MISAL  = 4'd6;
  localparam logic [3:0] ST_FAULT  = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_STORE,
    S_RESP,
    S_TRAP
  } state_t;

endpackage

// File: rtl/lsu_if.sv
// Bundle of the execute-side request/response and the data-memory port.
// slave: seen by lsu_ctrl (takes requests, drives memory controls).
// master: seen by the requester/memory side (drives requests and d_out).
interface lsu_if;
  // execute-stage request
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  // response / trap
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        trap;
  logic [3:0]  trap_cause;
  logic [31:0] trap_val;
  // data memory port
  logic        mrd;
  logic        mwr;
  logic [31:0] adr;
  logic [31:0] d_in;
  logic [31:0] d_out;

  modport slave (
    input  req, we, funct3, addr, wdata, d_out,
    output busy, done, rdata, trap, trap_cause, trap_val, mrd, mwr, adr, d_in
  );

  modport master (
    output req, we, funct3, addr, wdata, d_out,
    input  busy, done, rdata, trap, trap_cause, trap_val, mrd, mwr, adr, d_in
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: extract+extend for loads, byte/half merge for RMW stores.
// Ports: funct3/off select width and lane; word is the memory word; wdata the store data;
// load_val is the extended load result; merged is word with the new lane inserted.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  always_comb begin
    shifted = word >> {off, 3'b000};
    case (funct3)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_val = {24'h0, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_val = {16'h0, shifted[15:0]};
      default: load_val = word;
    endcase
  end

  // Replicate the store lane across the word, then let the mask pick the target lane.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        ins  = {4{wdata[7:0]}};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        ins  = {2{wdata[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wdata;
      end
    endcase
    merged = (word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access at a time toward a word-wide data memory,
// with RMW for byte/half stores and trap reporting for bad requests.
// Ports: clk, rst_n (async active-low), bus (lsu_if.slave: request, response, memory port).
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  bus
);

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] store_q;   // wdata at accept, replaced by the merged word after RMW_RD
  logic [31:0] rdata_q;
  logic [3:0]  cause_q;
  logic [31:0] tval_q;

  logic        f3_ill, misal, oor;
  logic [32:0] last_byte;
  logic [3:0]  req_cause;
  logic [31:0] load_val, merged;

  lsu_align u_align (
    .funct3   (f3_q),
    .off      (addr_q[1:0]),
    .word     (bus.d_out),
    .wdata    (store_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // Request classification from the live inputs, evaluated while IDLE.
  always_comb begin
    f3_ill    = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                (bus.we && bus.funct3[2]);
    misal     = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                ((bus.funct3 == F3_W) && (bus.addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    last_byte = {1'b0, bus.addr[31:2], 2'b00} + 33'd3;
    oor       = last_byte >= 33'(MEM_BYTES);
    req_cause = 4'd0;
    if (f3_ill)     req_cause = CAUSE_ILL;
    else if (misal) req_cause = bus.we ? ST_MISAL : LD_MISAL;
    else if (oor)   req_cause = bus.we ? ST_FAULT : LD_FAULT;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          if (req_cause != 4'd0)    state_nxt = S_TRAP;
          else if (!bus.we)         state_nxt = S_LOAD;
          else if (bus.funct3 == F3_W) state_nxt = S_STORE;
          else                      state_nxt = S_RMW_RD;
        end
      end
      S_LOAD:   state_nxt = S_RESP;
      S_RMW_RD: state_nxt = S_STORE;
      S_STORE:  state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      S_TRAP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      store_q <= 32'h0;
      rdata_q <= 32'h0;
      cause_q <= 4'd0;
      tval_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.req) begin
        we_q    <= bus.we;
        f3_q    <= bus.funct3;
        addr_q  <= bus.addr;
        store_q <= bus.wdata;
        cause_q <= req_cause;
        tval_q  <= (req_cause == CAUSE_ILL) ? 32'h0 : bus.addr;
      end
      if (state == S_LOAD)   rdata_q <= load_val;
      if (state == S_RMW_RD) store_q <= merged;
    end
  end

  // Memory strobes depend on state alone, so they cannot glitch from input activity.
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_RESP);
  assign bus.trap       = (state == S_TRAP);
  assign bus.trap_cause = bus.trap ? cause_q : 4'd0;
  assign bus.trap_val   = bus.trap ? tval_q : 32'h0;
  assign bus.mrd        = (state == S_LOAD) || (state == S_RMW_RD);
  assign bus.mwr        = (state == S_STORE);
  assign bus.adr        = {addr_q[31:2], 2'b00};
  assign bus.d_in       = bus.mwr ? store_q : 32'h0;
  assign bus.rdata      = rdata_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a word-wide memory model.
// Table of directed accesses plus sequences for reset-abort and held req.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if mif();

  lsu_ctrl #(.MEM_BYTES(65536)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  // memory model
  logic [31:0] mem [0:16383];
  logic        init_mem = 1'b0;
  int          mwr_total = 0;

  assign mif.d_out = mif.mrd ? mem[mif.adr[15:2]] : 32'h0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
      mem[14'h0400] <= 32'h80FF7F01;
      mem[14'h3FFF] <= 32'hDEADBEEF;
    end else if (mif.mwr && mif.adr < 32'd65536) begin
      mem[mif.adr[15:2]] <= mif.d_in;
    end
    if (mif.mwr) mwr_total <= mwr_total + 1;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic [31:0] rdata;
    int          cyc;
    int          nmrd;
    int          nmwr;
    logic [31:0] din;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  // results of one access
  logic        r_done, r_trap, r_both, r_timeout;
  logic [3:0]  r_cause;
  logic [31:0] r_tval, r_rdata, r_din, r_adr;
  int          r_cyc, r_mrd, r_mwr;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic trap, input logic [3:0] cause,
                              input logic [31:0] tval, input logic [31:0] rdata, input int cyc,
                              input int nmrd, input int nmwr, input logic [31:0] din);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.trap = trap; v.cause = cause;
    v.tval = tval; v.rdata = rdata; v.cyc = cyc; v.nmrd = nmrd; v.nmwr = nmwr; v.din = din;
    return v;
  endfunction

  // Issue one request, then watch up to 8 cycles for done/trap.
  task automatic apply(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic fin;
    @(negedge clk);
    mif.req = 1'b1; mif.we = we; mif.funct3 = f3; mif.addr = addr; mif.wdata = wdata;
    @(posedge clk);
    fin = 1'b0;
    r_done = 0; r_trap = 0; r_both = 0; r_timeout = 0; r_cause = 0; r_tval = 0;
    r_rdata = 0; r_din = 0; r_adr = 0; r_cyc = 0; r_mrd = 0; r_mwr = 0;
    for (int c = 1; c <= 8 && !fin; c++) begin
      @(negedge clk);
      mif.req = 1'b0;
      if (mif.mrd && mif.mwr) r_both = 1'b1;
      if ((mif.mrd || mif.mwr) && (r_mrd + r_mwr == 0)) r_adr = mif.adr;
      if (mif.mrd) r_mrd++;
      if (mif.mwr) begin r_mwr++; r_din = mif.d_in; end
      if (mif.done || mif.trap) begin
        fin = 1'b1; r_cyc = c; r_done = mif.done; r_trap = mif.trap;
        r_cause = mif.trap_cause; r_tval = mif.trap_val; r_rdata = mif.rdata;
      end
    end
    if (!fin) r_timeout = 1'b1;
  endtask

  logic [31:0] last_rd;
  logic [5:0]  mwr_pat, done_pat, busy_pat;
  int          mwr_snap;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, F3_B,   32'h1002, 0, 0, 0, 0, 32'hFFFFFFFF, 2, 1, 0, 0);
    vecs[1]  = mk(0, F3_BU,  32'h1002, 0, 0, 0, 0, 32'h000000FF, 2, 1, 0, 0);
    vecs[2]  = mk(0, F3_H,   32'h1002, 0, 0, 0, 0, 32'hFFFF80FF, 2, 1, 0, 0);
    vecs[3]  = mk(0, F3_HU,  32'h1002, 0, 0, 0, 0, 32'h000080FF, 2, 1, 0, 0);
    vecs[4]  = mk(0, F3_B,   32'h1003, 0, 0, 0, 0, 32'hFFFFFF80, 2, 1, 0, 0);
    vecs[5]  = mk(0, F3_H,   32'h1000, 0, 0, 0, 0, 32'h00007F01, 2, 1, 0, 0);
    vecs[6]  = mk(0, F3_W,   32'h1000, 0, 0, 0, 0, 32'h80FF7F01, 2, 1, 0, 0);
    vecs[7]  = mk(1, F3_B,   32'h1001, 32'h12345655, 0, 0, 0, 0, 3, 1, 1, 32'h80FF5501);
    vecs[8]  = mk(0, F3_W,   32'h1000, 0, 0, 0, 0, 32'h80FF5501, 2, 1, 0, 0);
    vecs[9]  = mk(1, F3_H,   32'h1003, 32'hAAAA, 1, ST_MISAL, 32'h1003, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, F3_W,   32'h1002, 0, 1, LD_MISAL, 32'h1002, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, F3_H,   32'h1001, 0, 1, LD_MISAL, 32'h1001, 0, 1, 0, 0, 0);
    vecs[12] = mk(0, F3_W,   32'hFFFC, 0, 0, 0, 0, 32'hDEADBEEF, 2, 1, 0, 0);
    vecs[13] = mk(0, F3_W,   32'h10000, 0, 1, LD_FAULT, 32'h10000, 0, 1, 0, 0, 0);
    vecs[14] = mk(0, F3_B,   32'hFFFFFFFF, 0, 1, LD_FAULT, 32'hFFFFFFFF, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 3'b011, 32'h1003, 0, 1, CAUSE_ILL, 0, 0, 1, 0, 0, 0);
    vecs[16] = mk(1, F3_BU,  32'h1000, 32'h55, 1, CAUSE_ILL, 0, 0, 1, 0, 0, 0);
    vecs[17] = mk(1, F3_W,   32'h10000, 32'h1, 1, ST_FAULT, 32'h10000, 0, 1, 0, 0, 0);
    vecs[18] = mk(1, F3_W,   32'h1006, 32'h1, 1, ST_MISAL, 32'h1006, 0, 1, 0, 0, 0);
    vecs[19] = mk(1, F3_H,   32'h2002, 32'hAAAABBBB, 0, 0, 0, 0, 3, 1, 1, 32'hBBBB0000);
    vecs[20] = mk(0, F3_H,   32'h2002, 0, 0, 0, 0, 32'hFFFFBBBB, 2, 1, 0, 0);
    vecs[21] = mk(1, F3_W,   32'h2004, 32'h11223344, 0, 0, 0, 0, 2, 0, 1, 32'h11223344);
    vecs[22] = mk(0, F3_W,   32'h2004, 0, 0, 0, 0, 32'h11223344, 2, 1, 0, 0);
    vecs[23] = mk(1, F3_B,   32'hFFFF, 32'h000000A5, 0, 0, 0, 0, 3, 1, 1, 32'hA5ADBEEF);
    vecs[24] = mk(0, F3_BU,  32'hFFFF, 0, 0, 0, 0, 32'h000000A5, 2, 1, 0, 0);
    vecs[25] = mk(1, 3'b110, 32'h1001, 32'h1, 1, CAUSE_ILL, 0, 0, 1, 0, 0, 0);

    mif.req = 1'b0; mif.we = 1'b0; mif.funct3 = 3'b000; mif.addr = 32'h0; mif.wdata = 32'h0;
    init_mem = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;

    // reset state
    chk("reset_busy",  0, {31'h0, mif.busy}, 0);
    chk("reset_done",  0, {31'h0, mif.done}, 0);
    chk("reset_trap",  0, {31'h0, mif.trap}, 0);
    chk("reset_mrd_mwr", 0, {30'h0, mif.mrd, mif.mwr}, 0);
    chk("reset_adr",   0, mif.adr, 0);
    chk("reset_rdata", 0, mif.rdata, 0);
    chk("reset_cause_val", 0, {28'h0, mif.trap_cause} | mif.trap_val | mif.d_in, 0);
    rst_n = 1'b1;

    // reset asserted during RMW_RD of SB 0x1000: no write may happen
    @(negedge clk);
    mif.req = 1'b1; mif.we = 1'b1; mif.funct3 = F3_B; mif.addr = 32'h1000; mif.wdata = 32'hAB;
    @(posedge clk);
    @(negedge clk);
    mif.req = 1'b0;
    chk("rmw_rd_mrd", 100, {30'h0, mif.mrd, mif.mwr}, 32'h2);
    mwr_snap = mwr_total;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", 100, {28'h0, mif.busy, mif.mrd, mif.mwr, mif.done} | mif.rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_mwr", 100, 32'(mwr_total - mwr_snap), 0);
    chk("abort_mem", 100, mem[14'h0400], 32'h80FF7F01);
    chk("abort_busy", 100, {31'h0, mif.busy}, 0);

    // table-driven accesses
    last_rd = 32'h0;
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      chk("timeout", i, {31'h0, r_timeout}, 0);
      chk("outcome", i, {30'h0, r_trap, r_done}, vecs[i].trap ? 32'h2 : 32'h1);
      chk("cycles", i, 32'(r_cyc), 32'(vecs[i].cyc));
      chk("mrd_cycles", i, 32'(r_mrd), 32'(vecs[i].nmrd));
      chk("mwr_cycles", i, 32'(r_mwr), 32'(vecs[i].nmwr));
      chk("mrd_mwr_excl", i, {31'h0, r_both}, 0);
      if (vecs[i].trap) begin
        chk("trap_cause", i, {28'h0, r_cause}, {28'h0, vecs[i].cause});
        chk("trap_val", i, r_tval, vecs[i].tval);
      end else if (!vecs[i].we) begin
        last_rd = vecs[i].rdata;
      end
      chk("rdata", i, r_rdata, last_rd);
      if (vecs[i].nmrd + vecs[i].nmwr > 0)
        chk("adr", i, r_adr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].nmwr > 0)
        chk("d_in", i, r_din, vecs[i].din);
    end

    // req held high through a SW: re-accepted only from IDLE after done
    @(negedge clk);
    mif.req = 1'b1; mif.we = 1'b1; mif.funct3 = F3_W; mif.addr = 32'h2008; mif.wdata = 32'h5A5A0001;
    @(posedge clk);
    mwr_snap = mwr_total;
    mwr_pat = 0; done_pat = 0; busy_pat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) mif.req = 1'b0;
      mwr_pat[c-1]  = mif.mwr;
      done_pat[c-1] = mif.done;
      busy_pat[c-1] = mif.busy;
    end
    @(negedge clk);
    chk("held_mwr_pattern", 200, {26'h0, mwr_pat}, 32'h09);
    chk("held_done_pattern", 200, {26'h0, done_pat}, 32'h12);
    chk("held_busy_pattern", 200, {26'h0, busy_pat}, 32'h1B);
    chk("held_mwr_total", 200, 32'(mwr_total - mwr_snap), 2);
    chk("held_mem", 200, mem[14'h0802], 32'h5A5A0001);
    chk("held_idle_after", 200, {31'h0, mif.busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
